// File: rtl/fwd_operand_mux_pipe_pkg.sv
// fwd_operand_mux_pipe_pkg
//   Shared constants for the EX-stage operand forwarding mux.
//   - FWD_SEL_* : forwarding select codes driven by the hazard/forwarding unit
//   - FWD_WIDTH_DEFAULT : default operand width
//   - fwd_sel_in_range : select-code decode helper (zero-extended compare)
package fwd_operand_mux_pipe_pkg;

  localparam int unsigned FWD_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    FWD_SEL_RF  = 2'd0,
    FWD_SEL_MEM = 2'd1,
    FWD_SEL_WB  = 2'd2
  } fwd_sel_e;

  // The select code is compared as an unsigned value against the number of
  // implemented sources; anything at or above that count is illegal.
  function automatic logic fwd_sel_in_range(input logic [31:0] sel_ext,
                                            input int unsigned num_in);
    return (sel_ext < num_in);
  endfunction

endpackage

// File: rtl/fwd_operand_mux_pipe_stage.sv
// fwd_pipe_stage
//   One register stage of the forwarding operand pipe, holding
//   {valid, err, data}. Priority: reset > flush > stall > advance.
//   Flush clears only valid/err; data keeps its old contents.
// Ports:
//   clk, reset        : rising-edge clock, synchronous active-high reset
//   stall, flush      : hold / invalidate control
//   d_valid/d_err/d_data : stage input
//   q_valid/q_err/q_data : registered stage output
module fwd_pipe_stage
  import fwd_operand_mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH = FWD_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic             d_valid,
  input  logic             d_err,
  input  logic [WIDTH-1:0] d_data,
  output logic             q_valid,
  output logic             q_err,
  output logic [WIDTH-1:0] q_data
);

  always_ff @(posedge clk) begin
    if (reset) begin
      q_valid <= 1'b0;
      q_err   <= 1'b0;
      q_data  <= '0;
    end else if (flush) begin
      q_valid <= 1'b0;
      q_err   <= 1'b0;
    end else if (!stall) begin
      q_valid <= d_valid;
      q_err   <= d_err;
      q_data  <= d_data;
    end
  end

endmodule

// File: rtl/fwd_operand_mux_pipe.sv
// fwd_operand_mux_pipe
//   Registered N:1 operand forwarding mux for the EX stage. A combinational
//   front end selects one of NUM_IN packed sources by `sel`; the result then
//   travels through STAGES register stages with stall/flush control.
//   Illegal select codes (sel >= NUM_IN) yield a zero word, and when the
//   operand is valid also raise sel_err at the output.
// Parameters: WIDTH (operand bits), NUM_IN (2..8), SEL_W (2**SEL_W >= NUM_IN),
//   STAGES (1..3).
// Ports:
//   clk, reset  : rising-edge clock, synchronous active-high reset
//   in_valid    : sel/data_in belong to a real instruction
//   sel         : source index, 0 selects data_in[WIDTH-1:0]
//   data_in     : packed sources, source k = data_in[k*WIDTH +: WIDTH]
//   stall/flush : hold all stages / invalidate all stages (flush wins)
//   out_valid, data_out, sel_err : last-stage outputs
//   err_cnt     : (FWD_MUX_ERR_CNT_EN only) saturating count of cycles with
//                 sel_err = 1 and stall = 0; cleared only by reset
// Build option: define FWD_MUX_ERR_CNT_EN to add err_cnt.
module fwd_operand_mux_pipe
  import fwd_operand_mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = FWD_WIDTH_DEFAULT,
  parameter int unsigned NUM_IN = 3,
  parameter int unsigned SEL_W  = 2,
  parameter int unsigned STAGES = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_IN*WIDTH-1:0] data_in,
  input  logic                    stall,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        data_out,
  output logic                    sel_err
`ifdef FWD_MUX_ERR_CNT_EN
  ,
  output logic [7:0]              err_cnt
`endif
);

  logic [31:0]      sel_ext;
  logic             sel_ok;
  logic [WIDTH-1:0] mux;
  logic             err_next;

  // Front end: the loop walks only the implemented sources, so an
  // out-of-range code never matches and the word stays at its zero default.
  always_comb begin
    sel_ext  = 32'(sel);
    sel_ok   = fwd_sel_in_range(sel_ext, NUM_IN);
    mux      = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel_ext == k) begin
        mux = data_in[k*WIDTH +: WIDTH];
      end
    end
    err_next = in_valid & ~sel_ok;
  end

  logic             st_valid [STAGES];
  logic             st_err   [STAGES];
  logic [WIDTH-1:0] st_data  [STAGES];

  for (genvar i = 0; i < STAGES; i++) begin : g_stage
    if (i == 0) begin : g_first
      fwd_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .d_valid (in_valid),
        .d_err   (err_next),
        .d_data  (mux),
        .q_valid (st_valid[i]),
        .q_err   (st_err[i]),
        .q_data  (st_data[i])
      );
    end else begin : g_next
      fwd_pipe_stage #(
        .WIDTH (WIDTH)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .flush   (flush),
        .d_valid (st_valid[i-1]),
        .d_err   (st_err[i-1]),
        .d_data  (st_data[i-1]),
        .q_valid (st_valid[i]),
        .q_err   (st_err[i]),
        .q_data  (st_data[i])
      );
    end
  end

  assign out_valid = st_valid[STAGES-1];
  assign sel_err   = st_err[STAGES-1];
  assign data_out  = st_data[STAGES-1];

`ifdef FWD_MUX_ERR_CNT_EN
  // Counts the registered error flag, so a stalled error cycle is counted
  // once when it finally advances; flush leaves the count untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= '0;
    end else if (sel_err && !stall && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_operand_mux_pipe.sv
module tb_fwd_operand_mux_pipe;

  localparam int W  = 32;
  localparam int N  = 3;
  localparam int SW = 2;
  localparam int ND = 3;   // DUT copies with STAGES = 1, 2, 3

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              in_valid = 1'b0;
  logic [SW-1:0]     sel = '0;
  logic [N*W-1:0]    data_in = '0;
  logic              stall = 1'b0;
  logic              flush = 1'b0;
  logic              ov   [ND];
  logic              se   [ND];
  logic [W-1:0]      dout [ND];
`ifdef FWD_MUX_ERR_CNT_EN
  logic [7:0]        ecnt [ND];
`endif

  logic [W-1:0] src [N];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < ND; g++) begin : g_dut
    fwd_operand_mux_pipe #(
      .WIDTH  (W),
      .NUM_IN (N),
      .SEL_W  (SW),
      .STAGES (g + 1)
    ) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .sel       (sel),
      .data_in   (data_in),
      .stall     (stall),
      .flush     (flush),
      .out_valid (ov[g]),
      .data_out  (dout[g]),
      .sel_err   (se[g])
`ifdef FWD_MUX_ERR_CNT_EN
      ,
      .err_cnt   (ecnt[g])
`endif
    );
  end

  // Reference model: a log of every operand accepted on an advancing edge.
  // A depth-S pipe shows the S-th most recent accepted operand; it is valid
  // only if no flush/reset has happened since it was accepted.
  typedef struct packed {
    logic         v;
    logic         e;
    logic [W-1:0] d;
  } cap_t;

  cap_t acc_log[$];
  int   base_idx = 0;   // first log entry after the latest reset
  int   kill_idx = 0;   // entries below this were flushed or reset away
  int   cnt_m [ND];

  function automatic cap_t model_out(input int s);
    cap_t r;
    int   idx;
    r.v = 1'b0;
    r.e = 1'b0;
    r.d = '0;
    if (acc_log.size() - base_idx >= s) begin
      idx = acc_log.size() - s;
      r   = acc_log[idx];
      if (idx < kill_idx) begin
        r.v = 1'b0;
        r.e = 1'b0;
      end
    end
    return r;
  endfunction

  function automatic logic model_known_zero(input int s);
    return (acc_log.size() - base_idx < s);
  endfunction

  task automatic check_all();
    cap_t e;
    for (int d = 0; d < ND; d++) begin
      e = model_out(d + 1);
      checks++;
      assert (ov[d] === e.v) else begin
        errors++;
        $error("FAIL model_out_valid S=%0d got=%0b exp=%0b", d + 1, ov[d], e.v);
      end
      checks++;
      assert (se[d] === e.e) else begin
        errors++;
        $error("FAIL model_sel_err S=%0d got=%0b exp=%0b", d + 1, se[d], e.e);
      end
      if (e.v || model_known_zero(d + 1)) begin
        checks++;
        assert (dout[d] === e.d) else begin
          errors++;
          $error("FAIL model_data_out S=%0d got=%h exp=%h", d + 1, dout[d], e.d);
        end
      end
`ifdef FWD_MUX_ERR_CNT_EN
      checks++;
      assert (ecnt[d] === 8'(cnt_m[d])) else begin
        errors++;
        $error("FAIL model_err_cnt S=%0d got=%0d exp=%0d", d + 1, ecnt[d], cnt_m[d]);
      end
`endif
    end
  endtask

  // One clock: drive inputs, advance the model, wait for the edge, check.
  task automatic cyc(input logic r, input logic iv, input int s,
                     input logic st, input logic fl);
    cap_t c;
    reset    = r;
    in_valid = iv;
    sel      = SW'(s);
    stall    = st;
    flush    = fl;
    data_in  = {src[2], src[1], src[0]};
    for (int d = 0; d < ND; d++) begin
      if (r) cnt_m[d] = 0;
      else if (!st && model_out(d + 1).e && cnt_m[d] < 255) cnt_m[d]++;
    end
    if (r) begin
      base_idx = acc_log.size();
      kill_idx = acc_log.size();
    end else if (fl) begin
      kill_idx = acc_log.size();
    end else if (!st) begin
      c.v = iv;
      c.e = iv && (s >= N);
      c.d = (s < N) ? src[s] : '0;
      acc_log.push_back(c);
    end
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic expect_out(input int d, input logic v, input logic [W-1:0] dat,
                            input logic e, input logic chk_d, input string tag);
    checks++;
    assert (ov[d] === v) else begin
      errors++;
      $error("FAIL %s out_valid S=%0d got=%0b exp=%0b", tag, d + 1, ov[d], v);
    end
    checks++;
    assert (se[d] === e) else begin
      errors++;
      $error("FAIL %s sel_err S=%0d got=%0b exp=%0b", tag, d + 1, se[d], e);
    end
    if (chk_d) begin
      checks++;
      assert (dout[d] === dat) else begin
        errors++;
        $error("FAIL %s data_out S=%0d got=%h exp=%h", tag, d + 1, dout[d], dat);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) cnt_m[d] = 0;
    src[0] = 32'h11111111;
    src[1] = 32'h22222222;
    src[2] = 32'h33333333;

    // Reset for two cycles: everything zero.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) expect_out(d, 1'b0, '0, 1'b0, 1'b1, "reset");
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) expect_out(d, 1'b0, '0, 1'b0, 1'b0, "idle");

    // Select sweep on the single-stage copy.
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
    expect_out(0, 1'b1, 32'h11111111, 1'b0, 1'b1, "sweep0");
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0);
    expect_out(0, 1'b1, 32'h22222222, 1'b0, 1'b1, "sweep1");
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    expect_out(0, 1'b1, 32'h33333333, 1'b0, 1'b1, "sweep2");

    // Illegal select, valid and then bubble.
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
    expect_out(0, 1'b1, 32'h0, 1'b1, 1'b1, "illegal_v");
    cyc(1'b0, 1'b0, 3, 1'b0, 1'b0);
    expect_out(0, 1'b0, 32'h0, 1'b0, 1'b0, "illegal_bubble");

    // Stall hold on the two-stage copy.
    src[0] = 32'hAAAA0001;
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
    src[0] = 32'hAAAA0002;
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
    expect_out(1, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, "stall_pre");
    src[0] = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b1, 1, 1'b1, 1'b0);
      expect_out(1, 1'b1, 32'hAAAA0001, 1'b0, 1'b1, "stall_hold");
    end
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    expect_out(1, 1'b1, 32'hAAAA0002, 1'b0, 1'b1, "stall_release");

    // Flush together with stall.
    src[0] = 32'h11111111;
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0);
    expect_out(1, 1'b1, 32'h22222222, 1'b0, 1'b1, "flush_pre");
    cyc(1'b0, 1'b1, 2, 1'b1, 1'b1);
    for (int d = 0; d < ND; d++) expect_out(d, 1'b0, '0, 1'b0, 1'b0, "flush_stall");
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) expect_out(d, 1'b0, '0, 1'b0, 1'b0, "flush_after");
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    expect_out(0, 1'b1, 32'h33333333, 1'b0, 1'b1, "refill_s1");
    expect_out(1, 1'b0, '0, 1'b0, 1'b0, "refill_s2_wait");
    cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
    expect_out(1, 1'b1, 32'h33333333, 1'b0, 1'b1, "refill_s2");

    // Reset with three operands in flight on the three-stage copy.
    cyc(1'b0, 1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 2, 1'b0, 1'b0);
    expect_out(2, 1'b1, 32'h11111111, 1'b0, 1'b1, "midrst_pre");
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    expect_out(2, 1'b0, '0, 1'b0, 1'b1, "midrst_reset");
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b0);
      expect_out(2, 1'b0, '0, 1'b0, 1'b0, "midrst_drain");
    end

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      for (int k = 0; k < N; k++) src[k] = $urandom;
      cyc(($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)),
          int'($urandom_range(0, 3)), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0));
    end

`ifdef FWD_MUX_ERR_CNT_EN
    // Error counter saturation.
    cyc(1'b1, 1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 300; i++) cyc(1'b0, 1'b1, 3, 1'b0, 1'b0);
    for (int d = 0; d < ND; d++) begin
      checks++;
      assert (ecnt[d] === 8'd255) else begin
        errors++;
        $error("FAIL err_cnt_sat S=%0d got=%0d exp=255", d + 1, ecnt[d]);
      end
    end
    cyc(1'b0, 1'b1, 3, 1'b0, 1'b1);
    checks++;
    assert (ecnt[0] === 8'd255) else begin
      errors++;
      $error("FAIL err_cnt_flush got=%0d exp=255", ecnt[0]);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
